// File: rtl/fetch_decode_ctrl_if.sv
// Bus bundle for fetch_decode_ctrl: instruction-memory read channel,
// decoded-op issue channel and branch-resolution inputs.
// master = the controller, slave = memory/datapath side.
interface fetch_decode_ctrl_if #(
    parameter int PCW = 8,
    parameter int IW  = 9
);
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic           imem_valid;
    logic [IW-1:0]  imem_rdata;
    logic [4:0]     alu_op;
    logic [3:0]     operand;
    logic           op_valid;
    logic           ex_ready;
    logic           br_valid;
    logic           br_taken;
    logic [PCW-1:0] br_target;

    modport master (
        output imem_req, imem_addr, alu_op, operand, op_valid,
        input  imem_valid, imem_rdata, ex_ready, br_valid, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, alu_op, operand, op_valid,
        output imem_valid, imem_rdata, ex_ready, br_valid, br_taken, br_target
    );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Instruction fetch/decode controller. Owns the PC, fetches one 9-bit word
// per request, decodes it into the 5-bit ALU opcode space and issues it with
// a ready/valid handshake; kBRH waits for datapath branch resolution.
// Optional build macro ILLEGAL_TRAP_EN: an undefined opcode halts the
// program at the faulting pc instead of issuing as kNOP.
module fetch_decode_ctrl #(
    parameter int            PCW       = 8,
    parameter int            IW        = 9,
    parameter logic [IW-1:0] HALT_WORD = 9'h1FF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    fetch_decode_ctrl_if.master bus,
    output logic [PCW-1:0]      pc,
    output logic                done,
    output logic                illegal
);
    localparam logic [4:0] K_NOP  = 5'd9;
    localparam logic [4:0] K_BRH  = 5'd17;
    localparam logic [4:0] K_NOPB = 5'd19;
    localparam logic [4:0] K_LAST = 5'd19;

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, BRANCH, HALT} state_t;
    state_t state;

    logic [4:0] fetched_op;
    logic       undef;

    assign fetched_op    = bus.imem_rdata[IW-1:4];
    assign undef         = fetched_op > K_LAST;
    assign bus.imem_addr = pc;

    // Control FSM; every output is registered and updated with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc           <= '0;
            bus.alu_op   <= K_NOP;
            bus.operand  <= '0;
            bus.op_valid <= 1'b0;
            bus.imem_req <= 1'b0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc           <= '0;
                        bus.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    // imem_req is high for the whole state, so imem_valid
                    // here always belongs to our outstanding request.
                    if (bus.imem_valid) begin
                        bus.imem_req <= 1'b0;
                        if (bus.imem_rdata == HALT_WORD) begin
                            done  <= 1'b1;
                            state <= HALT;
                        end
`ifdef ILLEGAL_TRAP_EN
                        else if (undef) begin
                            // pc stays on the faulting word for inspection
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            state   <= HALT;
                        end
`endif
                        else begin
                            bus.op_valid <= 1'b1;
                            bus.alu_op   <= undef ? K_NOP : fetched_op;
                            bus.operand  <= bus.imem_rdata[3:0];
                            if (undef) illegal <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // alu_op/operand are held until the datapath accepts
                    if (bus.ex_ready) begin
                        bus.op_valid <= 1'b0;
                        if (bus.alu_op == K_BRH) begin
                            bus.alu_op <= K_NOPB;
                            state      <= BRANCH;
                        end else begin
                            pc           <= pc + 1'b1;
                            bus.alu_op   <= K_NOP;
                            bus.imem_req <= 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                BRANCH: begin
                    if (bus.br_valid) begin
                        pc           <= bus.br_taken ? bus.br_target : pc + 1'b1;
                        bus.alu_op   <= K_NOP;
                        bus.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
                HALT: begin
                    if (start) begin
                        done         <= 1'b0;
                        illegal      <= 1'b0;
                        pc           <= '0;
                        bus.imem_req <= 1'b1;
                        state        <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
